prefetch_issue_queue: RTL and testbench
=======================================

# prefetch_issue_queue

Buffers prefetch requests from the L1 data-cache prefetcher and issues them one at a time to the MSHR allocation path. It sits directly downstream of the prefetcher's decoupled prefetch output. It line-aligns each request, filters out duplicate lines, drops requests rather than back-pressuring the prefetcher, and holds issue while no MSHR is free. It also keeps saturating statistics counters for dropped and filtered requests.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2)
- HIST, 4: recently-issued line history entries
- ADDR_W, 40: physical address width
- LINE_OFF, 6: log2 of cache line bytes

Ports:
- clock  in  1  single block clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = in reset); clears all state immediately
- io_in_valid  in  1  prefetcher request valid
- io_in_ready  out  1  tied 1 out of reset; requests are never back-pressured
- io_in_addr  in  ADDR_W  prefetch byte address
- io_mshr_avail  in  1  at least one MSHR free this cycle
- io_flush  in  1  discard all queued requests and history
- io_out_valid  out  1  request offered to MSHR path
- io_out_ready  in  1  MSHR path accepts
- io_out_addr  out  ADDR_W  line-aligned address, low LINE_OFF bits zero
- io_out_cmd  out  5  constant 5'h2 (prefetch-read command)
- io_stat_dropped  out  16  saturating count of requests dropped because the queue was full
- io_stat_filtered  out  16  saturating count of requests removed as duplicates

## Operation
- Line address: L = io_in_addr with bits [LINE_OFF-1:0] forced to 0.
- Accepting a request is decided when io_in_valid=1 and io_flush=0, in this priority order:
  - match: L equals any valid FIFO entry (including a head dequeuing this cycle) or any valid history entry → not stored; io_stat_filtered += 1.
  - full: registered count == DEPTH at the start of the cycle → not stored; io_stat_dropped += 1. A dequeue in the same cycle does not free space for the incoming request.
  - otherwise: L is written at the tail; tail advances modulo DEPTH; count += 1.
- Issue:
  - io_out_valid = (count != 0) && io_mshr_avail.
  - io_out_addr = the head entry.
  - On io_out_valid && io_out_ready: head advances modulo DEPTH, count -= 1, and the head line is written into the history at a round-robin pointer (modulo HIST) and marked valid.
- Simultaneous enqueue and dequeue when not full: count is unchanged and both pointers advance.
- Flush:
  - Clears count, head, tail, all history valid bits, and the history pointer.
  - Any input in the flush cycle is ignored and not counted.
  - io_out_valid is still computed from the pre-flush state in that cycle; a handshake in the flush cycle counts as issued.
  - Statistics counters are not cleared.
- Statistics counters hold at 16'hFFFF once reached.
- io_mshr_avail is combinational into io_out_valid only; it never affects acceptance.

## Timing
- Reset values: count=0, head=tail=0, all FIFO and history valid=0, history pointer=0, io_out_valid=0, io_out_addr=0, both statistics counters=0.
- io_in_ready is 0 while in reset and 1 otherwise.
- Latency: a request accepted in cycle N can be presented on io_out_valid in cycle N+1 at the earliest. There is no combinational path from input to output.
- Throughput: one enqueue and one dequeue per cycle.
- io_out_addr is a registered FIFO value and remains stable while io_out_valid=1 and io_out_ready=0.
- io_out_valid may deassert without a handshake when io_mshr_avail drops; this is allowed by the consumer.
- Reset asserted mid-operation: all state clears asynchronously; io_out_valid falls within the same cycle.

## Test plan
- Basic issue: reset release, then in 0x80001234 with mshr_avail=1 and out_ready=1 → next cycle out_valid=1, out_addr=0x80001200, out_cmd=5'h2; after the handshake count=0.
- Filter: in 0x1000, then 0x1008, then 0x103F on consecutive cycles with out_ready=0 → one entry queued, stat_filtered=2. Issue it, then in 0x1010 → filtered via history, stat_filtered=3.
- Full/drop: mshr_avail=0, in lines 0x0, 0x40, 0x80, 0xC0, 0x100 → count=4, out_valid=0, stat_dropped=1. Then mshr_avail=1 with out_ready=1 → lines issued in order 0x0, 0x40, 0x80, 0xC0.
- Full with simultaneous dequeue: queue full, handshake and new line 0x200 in the same cycle → 0x200 dropped, count=3.
- Flush: 3 entries queued, io_flush=1 with in 0x400 → count=0 next cycle, 0x400 not stored, counters unchanged. Then 0x0 (previously issued) is accepted because the history was cleared.
- Saturation and reset: force 70000 drops → stat_dropped=0xFFFF. Assert reset mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/prefetch_issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_issue_queue_if
//  Description : Bundle of the prefetch request input, MSHR issue output and
//                statistics signals of the prefetch issue queue.
//                master : the surrounding logic (prefetcher + MSHR path)
//                slave  : the prefetch_issue_queue itself
//  Signals     : io_in_valid/io_in_ready/io_in_addr   prefetch request
//                io_mshr_avail                         MSHR free this cycle
//                io_flush                              discard queue/history
//                io_out_valid/io_out_ready/io_out_addr/io_out_cmd  issue
//                io_stat_dropped/io_stat_filtered      saturating counters
//  Revision    : 1.0  initial release
// ============================================================================
interface prefetch_issue_queue_if #(
    parameter int ADDR_W = 40
);
    logic              io_in_valid;
    logic              io_in_ready;
    logic [ADDR_W-1:0] io_in_addr;
    logic              io_mshr_avail;
    logic              io_flush;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [ADDR_W-1:0] io_out_addr;
    logic [4:0]        io_out_cmd;
    logic [15:0]       io_stat_dropped;
    logic [15:0]       io_stat_filtered;

    modport master (
        output io_in_valid,
        output io_in_addr,
        output io_mshr_avail,
        output io_flush,
        output io_out_ready,
        input  io_in_ready,
        input  io_out_valid,
        input  io_out_addr,
        input  io_out_cmd,
        input  io_stat_dropped,
        input  io_stat_filtered
    );

    modport slave (
        input  io_in_valid,
        input  io_in_addr,
        input  io_mshr_avail,
        input  io_flush,
        input  io_out_ready,
        output io_in_ready,
        output io_out_valid,
        output io_out_addr,
        output io_out_cmd,
        output io_stat_dropped,
        output io_stat_filtered
    );
endinterface
`default_nettype wire

// File: rtl/prefetch_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_issue_queue
//  Description : Buffers L1D prefetch requests and issues them one at a time
//                to the MSHR allocation path. Requests are line-aligned,
//                duplicates of queued or recently issued lines are filtered,
//                and a full queue drops requests instead of back-pressuring.
//                Issue is held while no MSHR is available.
//  Ports       : clock  - block clock, all state on rising edge
//                reset  - asynchronous active-low reset
//                bus    - prefetch_issue_queue_if.slave (request, issue,
//                         flush, MSHR availability, statistics)
//  Revision    : 1.0  initial release
// ============================================================================
module prefetch_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int HIST     = 4,
    parameter int ADDR_W   = 40,
    parameter int LINE_OFF = 6
) (
    input  wire logic             clock,
    input  wire logic             reset,
    prefetch_issue_queue_if.slave bus
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_hptr_w = (HIST > 1) ? $clog2(HIST) : 1;

    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_hptr_w-1:0] c_hist_last = c_hptr_w'(HIST - 1);
    localparam logic [ADDR_W-1:0]   c_line_mask =
        {{(ADDR_W - LINE_OFF){1'b1}}, {LINE_OFF{1'b0}}};
    localparam logic [4:0]          c_cmd_pf_read = 5'h2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   r_fifo_addr [DEPTH];
    logic [DEPTH-1:0]    r_fifo_vld;
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;

    logic [ADDR_W-1:0]   r_hist_addr [HIST];
    logic [HIST-1:0]     r_hist_vld;
    logic [c_hptr_w-1:0] r_hist_ptr;

    logic [15:0]         r_stat_dropped;
    logic [15:0]         r_stat_filtered;

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_line;
    logic [DEPTH-1:0]  w_fifo_hit;
    logic [HIST-1:0]   w_hist_hit;
    logic              w_match;
    logic              w_req;
    logic              w_full;
    logic              w_filter;
    logic              w_drop;
    logic              w_enq;
    logic              w_out_valid;
    logic              w_deq;

    assign w_line = bus.io_in_addr & c_line_mask;

    // Compare against every valid FIFO slot, including a head that is being
    // handed out this very cycle, so a line can never be queued twice.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo_cmp
            assign w_fifo_hit[gi] = r_fifo_vld[gi] && (r_fifo_addr[gi] == w_line);
        end
        for (genvar gh = 0; gh < HIST; gh++) begin : g_hist_cmp
            assign w_hist_hit[gh] = r_hist_vld[gh] && (r_hist_addr[gh] == w_line);
        end
    endgenerate

    assign w_match  = (|w_fifo_hit) || (|w_hist_hit);
    assign w_req    = bus.io_in_valid && !bus.io_flush;
    // Fullness uses the registered count only: a dequeue in the same cycle
    // does not make room for the incoming request.
    assign w_full   = (r_count == c_depth);
    assign w_filter = w_req && w_match;
    assign w_drop   = w_req && !w_match && w_full;
    assign w_enq    = w_req && !w_match && !w_full;

    assign w_out_valid = (r_count != '0) && bus.io_mshr_avail;
    assign w_deq       = w_out_valid && bus.io_out_ready;

    // ------------------------------------------------------------------
    // Queue pointers, valid bits and history
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fifo_vld <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_hist_vld <= '0;
            r_hist_ptr <= '0;
        end else if (bus.io_flush) begin
            // A handshake in the flush cycle still counts as issued on the
            // consumer side; its history entry is discarded with the rest.
            r_fifo_vld <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_hist_vld <= '0;
            r_hist_ptr <= '0;
        end else begin
            // Enqueue and dequeue never target the same slot: enqueue needs
            // a non-full queue, dequeue a non-empty one, so tail != head.
            if (w_enq) begin
                r_fifo_vld[r_tail] <= 1'b1;
                r_tail             <= r_tail + c_ptr_w'(1);
            end
            if (w_deq) begin
                r_fifo_vld[r_head]     <= 1'b0;
                r_head                 <= r_head + c_ptr_w'(1);
                r_hist_vld[r_hist_ptr] <= 1'b1;
                r_hist_ptr             <= (r_hist_ptr == c_hist_last) ?
                                          '0 : r_hist_ptr + c_hptr_w'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line storage (FIFO payload and history lines)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
            end
            for (int i = 0; i < HIST; i++) begin
                r_hist_addr[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_fifo_addr[r_tail] <= w_line;
            end
            if (w_deq && !bus.io_flush) begin
                r_hist_addr[r_hist_ptr] <= r_fifo_addr[r_head];
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics: saturating, untouched by flush
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_dropped  <= '0;
            r_stat_filtered <= '0;
        end else begin
            if (w_drop && (r_stat_dropped != 16'hFFFF)) begin
                r_stat_dropped <= r_stat_dropped + 16'd1;
            end
            if (w_filter && (r_stat_filtered != 16'hFFFF)) begin
                r_stat_filtered <= r_stat_filtered + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Ready simply follows the reset pin: low only while reset is held.
    assign bus.io_in_ready      = reset;
    assign bus.io_out_valid     = w_out_valid;
    assign bus.io_out_addr      = r_fifo_addr[r_head];
    assign bus.io_out_cmd       = c_cmd_pf_read;
    assign bus.io_stat_dropped  = r_stat_dropped;
    assign bus.io_stat_filtered = r_stat_filtered;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prefetch_issue_queue
//  Description : Self-checking bench for prefetch_issue_queue. A reference
//                model built from queues predicts issued lines and counters;
//                a monitor compares the DUT against it every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prefetch_issue_queue;

    localparam int DEPTH = 4;
    localparam int HIST  = 4;
    localparam int AW    = 40;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    prefetch_issue_queue_if #(.ADDR_W(AW)) bus ();

    prefetch_issue_queue #(
        .DEPTH    (DEPTH),
        .HIST     (HIST),
        .ADDR_W   (AW),
        .LINE_OFF (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: queued lines, last HIST issued lines, counters
    // ------------------------------------------------------------------
    logic [AW-1:0] m_fifo[$];
    logic [AW-1:0] m_hist[$];
    logic [AW-1:0] sb_q[$];     // expected issue order, popped by monitor
    int            m_drop = 0;
    int            m_filt = 0;

    function automatic bit contains(input logic [AW-1:0] q[$], input logic [AW-1:0] v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_fifo.delete();
            m_hist.delete();
            sb_q.delete();
            m_drop = 0;
            m_filt = 0;
        end else begin
            automatic logic [AW-1:0] line = bus.io_in_addr & ~(AW'(63));
            automatic int  pre_n = m_fifo.size();
            automatic bit  hs    = (pre_n != 0) && bus.io_mshr_avail && bus.io_out_ready;
            automatic bit  enq   = 1'b0;
            if (bus.io_in_valid && !bus.io_flush) begin
                if (contains(m_fifo, line) || contains(m_hist, line)) begin
                    if (m_filt < 65535) m_filt++;
                end else if (pre_n == DEPTH) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    enq = 1'b1;
                end
            end
            if (hs) begin
                m_hist.push_back(m_fifo.pop_front());
                if (m_hist.size() > HIST) void'(m_hist.pop_front());
            end
            if (enq) begin
                m_fifo.push_back(line);
                sb_q.push_back(line);
            end
            if (bus.io_flush) begin
                m_fifo.delete();
                m_hist.delete();
                sb_q.delete();
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples mid-cycle, pops the scoreboard on each handshake
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (reset) begin
            chk("out_valid", 64'(bus.io_out_valid), 64'((m_fifo.size() != 0) && bus.io_mshr_avail));
            chk("out_cmd", 64'(bus.io_out_cmd), 64'h2);
            chk("stat_dropped", 64'(bus.io_stat_dropped), 64'(m_drop));
            chk("stat_filtered", 64'(bus.io_stat_filtered), 64'(m_filt));
            if (bus.io_out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_issue", 64'(bus.io_out_addr), 64'hDEAD_BEEF_DEAD);
                end else begin
                    chk("out_addr", 64'(bus.io_out_addr), 64'(sb_q[0]));
                    if (bus.io_out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input bit v, input logic [AW-1:0] a, input bit mshr,
                        input bit rdy, input bit fl);
        bus.io_in_valid   = v;
        bus.io_in_addr    = a;
        bus.io_mshr_avail = mshr;
        bus.io_out_ready  = rdy;
        bus.io_flush      = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic rand_step();
        automatic logic [AW-1:0] a = AW'($urandom_range(0, 11)) << 6;
        a = a | AW'($urandom_range(0, 63));
        step($urandom_range(0, 99) < 70, a, $urandom_range(0, 99) < 75,
             $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
    endtask

    initial begin
        bus.io_in_valid   = 1'b0;
        bus.io_in_addr    = '0;
        bus.io_mshr_avail = 1'b0;
        bus.io_out_ready  = 1'b0;
        bus.io_flush      = 1'b0;
        #2;
        chk("rst_in_ready", 64'(bus.io_in_ready), 64'h0);
        chk("rst_out_valid", 64'(bus.io_out_valid), 64'h0);
        chk("rst_out_addr", 64'(bus.io_out_addr), 64'h0);
        chk("rst_dropped", 64'(bus.io_stat_dropped), 64'h0);
        chk("rst_filtered", 64'(bus.io_stat_filtered), 64'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("in_ready_after_reset", 64'(bus.io_in_ready), 64'h1);

        // Basic issue
        step(1, 40'h80001234, 1, 1, 0);
        chk("basic_valid", 64'(bus.io_out_valid), 64'h1);
        chk("basic_addr", 64'(bus.io_out_addr), 64'h80001200);
        step(0, 0, 1, 1, 0);
        chk("basic_empty", 64'(bus.io_out_valid), 64'h0);

        // Duplicate filtering in queue, then via history
        step(1, 40'h1000, 1, 0, 0);
        step(1, 40'h1008, 1, 0, 0);
        step(1, 40'h103F, 1, 0, 0);
        chk("filter_queue", 64'(bus.io_stat_filtered), 64'd2);
        step(0, 0, 1, 1, 0);
        step(1, 40'h1010, 1, 1, 0);
        chk("filter_hist", 64'(bus.io_stat_filtered), 64'd3);
        chk("filter_hist_empty", 64'(bus.io_out_valid), 64'h0);

        // Full queue drops
        step(1, 40'h0, 0, 1, 0);
        step(1, 40'h40, 0, 1, 0);
        step(1, 40'h80, 0, 1, 0);
        step(1, 40'hC0, 0, 1, 0);
        step(1, 40'h100, 0, 1, 0);
        chk("full_dropped", 64'(bus.io_stat_dropped), 64'd1);
        chk("full_held", 64'(bus.io_out_valid), 64'h0);
        for (int i = 0; i < 4; i++) begin
            bus.io_in_valid = 1'b0;
            bus.io_mshr_avail = 1'b1;
            #1;
            chk("drain_order", 64'(bus.io_out_addr), 64'(i * 64));
            step(0, 0, 1, 1, 0);
        end
        chk("drain_empty", 64'(bus.io_out_valid), 64'h0);

        // Full plus simultaneous dequeue still drops
        step(1, 40'h140, 0, 0, 0);
        step(1, 40'h180, 0, 0, 0);
        step(1, 40'h1C0, 0, 0, 0);
        step(1, 40'h240, 0, 0, 0);
        step(1, 40'h200, 1, 1, 0);
        chk("full_deq_dropped", 64'(bus.io_stat_dropped), 64'd2);
        repeat (3) step(0, 0, 1, 1, 0);
        chk("full_deq_count3", 64'(bus.io_out_valid), 64'h0);

        // Flush
        step(1, 40'h300, 0, 0, 0);
        step(1, 40'h340, 0, 0, 0);
        step(1, 40'h380, 0, 0, 0);
        step(1, 40'h400, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("flush_empty", 64'(bus.io_out_valid), 64'h0);
        chk("flush_filtered", 64'(bus.io_stat_filtered), 64'd3);
        chk("flush_dropped", 64'(bus.io_stat_dropped), 64'd2);
        step(1, 40'h0, 1, 0, 0);
        chk("flush_hist_clr_valid", 64'(bus.io_out_valid), 64'h1);
        chk("flush_hist_clr_addr", 64'(bus.io_out_addr), 64'h0);
        chk("flush_hist_clr_filt", 64'(bus.io_stat_filtered), 64'd3);
        step(0, 0, 1, 1, 0);

        // Randomized traffic
        repeat (3000) rand_step();

        // Saturating drop counter
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, AW'(32'h10000 + i) << 6, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(1, AW'(32'h20000 + i) << 6, 0, 0, 0);
        chk("sat_dropped", 64'(bus.io_stat_dropped), 64'hFFFF);
        step(1, 40'h7FFFFFC0, 0, 0, 0);
        chk("sat_hold", 64'(bus.io_stat_dropped), 64'hFFFF);

        // Asynchronous reset mid-stream
        step(0, 0, 1, 0, 0);
        chk("pre_reset_valid", 64'(bus.io_out_valid), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_valid", 64'(bus.io_out_valid), 64'h0);
        chk("async_out_addr", 64'(bus.io_out_addr), 64'h0);
        chk("async_in_ready", 64'(bus.io_in_ready), 64'h0);
        chk("async_dropped", 64'(bus.io_stat_dropped), 64'h0);
        chk("async_filtered", 64'(bus.io_stat_filtered), 64'h0);
        repeat (2) step(1, 40'h5000, 1, 1, 0);
        reset = 1'b1;
        repeat (300) rand_step();
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
